// File: rtl/pc_redirect_ctrl_if.sv
// -----------------------------------------------------------------------------
// pc_redirect_ctrl_if
// Bundle between the EX-stage jump decode / trap unit / fetch PC mux and the
// PC redirect controller.
//   Requests (master -> slave): ex_valid, ex_jump, ex_target, trap_req,
//                               trap_target, fetch_ready
//   Redirect (slave -> master): redirect_valid, redirect_pc, kill_if, kill_id,
//                               hold_ex, taken_count, trap_count
// The controller connects through the slave modport. The pipeline side, or a
// testbench, connects through the master modport.
// -----------------------------------------------------------------------------
interface pc_redirect_ctrl_if #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 32
);
    logic                 ex_valid;
    logic                 ex_jump;
    logic [PC_WIDTH-1:0]  ex_target;
    logic                 trap_req;
    logic [PC_WIDTH-1:0]  trap_target;
    logic                 fetch_ready;
    logic                 redirect_valid;
    logic [PC_WIDTH-1:0]  redirect_pc;
    logic                 kill_if;
    logic                 kill_id;
    logic                 hold_ex;
    logic [CNT_WIDTH-1:0] taken_count;
    logic [CNT_WIDTH-1:0] trap_count;

    modport master (
        output ex_valid, ex_jump, ex_target, trap_req, trap_target, fetch_ready,
        input  redirect_valid, redirect_pc, kill_if, kill_id, hold_ex,
               taken_count, trap_count
    );

    modport slave (
        input  ex_valid, ex_jump, ex_target, trap_req, trap_target, fetch_ready,
        output redirect_valid, redirect_pc, kill_if, kill_id, hold_ex,
               taken_count, trap_count
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// pc_redirect_ctrl
// Sequences every PC redirect into fetch: the boot vector after reset, taken
// jumps/branches resolved in EX, and trap redirects. A trap wins over a jump
// in the same cycle. The redirect is held in ISSUE until fetch accepts it.
// While a redirect is pending, IF/ID are killed and EX is frozen. Accepted
// jump and trap redirects are counted.
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset. It leaves the block in ISSUE
//              with the boot vector.
//   bus      : slave side of pc_redirect_ctrl_if. It carries the EX/trap
//              requests, the fetch handshake, the kill/hold controls and
//              the counters.
// -----------------------------------------------------------------------------
module pc_redirect_ctrl #(
    parameter int                  PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = 32'h0000_2000,
    parameter int                  CNT_WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    pc_redirect_ctrl_if.slave  bus
);
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [CNT_WIDTH-1:0] taken_q, taken_d;
    logic [CNT_WIDTH-1:0] trap_q, trap_d;
    logic                 req_s;
    logic                 kill_s;

    // A jump is only real when EX holds a valid instruction.
    assign req_s = bus.trap_req | (bus.ex_valid & bus.ex_jump);

    // State, target and counter registers. Reset discards any pending target.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_ISSUE;
            pc_q    <= RESET_PC;
            taken_q <= {CNT_WIDTH{1'b0}};
            trap_q  <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
            trap_q  <= trap_d;
        end
    end

    // Next state, target and counts. A trap seen in ISSUE replaces the target
    // whether or not fetch takes the current one this cycle. In both cases
    // the block stays in ISSUE so that the trap target is issued next.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        taken_d = taken_q;
        trap_d  = trap_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    state_d = ST_ISSUE;
                    if (bus.trap_req) begin
                        pc_d   = bus.trap_target;
                        trap_d = trap_q + CNT_ONE;
                    end else begin
                        pc_d    = bus.ex_target;
                        taken_d = taken_q + CNT_ONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // EX is frozen here, so ex_jump is not looked at.
                if (bus.trap_req) begin
                    state_d = ST_ISSUE;
                    pc_d    = bus.trap_target;
                    trap_d  = trap_q + CNT_ONE;
                end else if (bus.fetch_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_ISSUE;
                pc_d    = RESET_PC;
            end
        endcase
    end

    // Kill the wrong path as soon as a redirect is requested, and keep
    // killing it while the redirect is outstanding.
    always_comb begin
        kill_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    kill_s = 1'b1;
                end else begin
                    kill_s = 1'b0;
                end
            end
            ST_ISSUE: kill_s = 1'b1;
            default:  kill_s = 1'b1;
        endcase
    end

    assign bus.redirect_valid = (state_q == ST_ISSUE);
    assign bus.hold_ex        = (state_q == ST_ISSUE);
    assign bus.redirect_pc    = pc_q;
    assign bus.kill_if        = kill_s;
    assign bus.kill_id        = kill_s;
    assign bus.taken_count    = taken_q;
    assign bus.trap_count     = trap_q;

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Sequences all PC redirects into the fetch stage: boot vector, taken branches/jumps resolved in EX, and trap redirects.
- Arbitrates between the sources (trap > jump) and holds the redirect until fetch accepts it.
- Kills wrong-path instructions in IF/ID and freezes EX while a redirect is outstanding.
- Keeps taken-jump and trap performance counters. Sits between the EX-stage jump decode and the fetch PC mux.

Parameters:
PC_WIDTH, 32, width of PC and target buses
RESET_PC, 32'h0000_2000, boot vector issued after reset
CNT_WIDTH, 32, width of performance counters

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX holds a real instruction (not a bubble)
ex_jump  in  1  jump/branch-taken from EX jump decode (JAL, JALR, taken branch)
ex_target  in  PC_WIDTH  jump/branch target computed in EX
trap_req  in  1  trap/exception redirect request
trap_target  in  PC_WIDTH  trap handler address
fetch_ready  in  1  fetch accepts redirect_pc this cycle
redirect_valid  out  1  redirect_pc is valid for fetch
redirect_pc  out  PC_WIDTH  PC fetch must load
kill_if  out  1  convert IF-stage instruction to bubble
kill_id  out  1  convert ID-stage instruction to bubble
hold_ex  out  1  freeze EX and upstream stages
taken_count  out  CNT_WIDTH  accepted jump redirects
trap_count  out  CNT_WIDTH  accepted trap redirects

Behaviour:
- States: IDLE, ISSUE. redirect_valid = (state == ISSUE), driven from the register; hold_ex = (state == ISSUE).
- Reset (async, reset_n = 0):
  - state = ISSUE, redirect_pc = RESET_PC.
  - taken_count = 0, trap_count = 0.
  - Outputs therefore come out of reset as redirect_valid = 1 and hold_ex = 1.
  - Reset asserted mid-operation discards any pending target and returns to this state immediately.
- Request in IDLE: req = trap_req | (ex_valid & ex_jump). ex_jump with ex_valid = 0 is ignored.
- Arbitration: if trap_req, load trap_target and increment trap_count. Otherwise load ex_target and increment taken_count. The losing jump is dropped (trap flushes it).
- IDLE with req at cycle N:
  - kill_if = 1 and kill_id = 1 combinationally in cycle N.
  - Next state = ISSUE, redirect_pc registered. redirect_valid is seen at N+1 (1-cycle latency).
- IDLE without req: all kill/hold outputs 0; redirect_pc holds its last value.
- ISSUE:
  - kill_if = 1 and kill_id = 1 every cycle.
  - redirect_pc is stable while fetch_ready = 0.
  - ex_jump is ignored, since EX is frozen.
- ISSUE, fetch_ready = 1, trap_req = 0: handshake completes, next state = IDLE. Minimum redirect lifetime is 1 cycle.
- ISSUE, fetch_ready = 0, trap_req = 1: redirect_pc is replaced by trap_target; stay ISSUE; trap_count++. The superseded target is not counted again.
- ISSUE, fetch_ready = 1, trap_req = 1: the current target is accepted this cycle. trap_target is loaded, trap_count++, and the block stays ISSUE, so the trap is issued next cycle.
- Boot redirect (first ISSUE after reset) does not increment either counter.
- Counters: wrap modulo 2^CNT_WIDTH with no saturation. They update on the clock edge that latches the request.
- No combinational path from fetch_ready to redirect_pc.

Test Plan:
- Reset release, fetch_ready = 0 for 3 cycles then 1 -> redirect_valid = 1, redirect_pc = 0x2000, and hold_ex = 1 for 4 cycles. redirect_valid = 0 the cycle after the handshake; counters stay 0.
- IDLE, ex_valid = 1, ex_jump = 1, ex_target = 0x2040 at cycle N, fetch_ready = 1 -> kill_if and kill_id = 1 at N. redirect_valid = 1 with redirect_pc = 0x2040 at N+1, IDLE at N+2, taken_count = 1.
- IDLE, ex_jump = 1 (target 0x3000) and trap_req = 1 (target 0x1C0) in the same cycle -> redirect_pc = 0x1C0, trap_count = 1, taken_count = 0.
- ISSUE with target 0x2080 and fetch_ready = 0; trap_req pulses with 0x1C0 -> redirect_pc changes to 0x1C0 the next cycle. Then with fetch_ready = 1 -> accepted; trap_count = 1, taken_count = 1.
- ISSUE, fetch_ready = 1 and trap_req = 1 (0x1C0) in the same cycle -> the old target is accepted, and redirect_valid stays 1 with redirect_pc = 0x1C0 the next cycle. ex_valid = 1 with ex_jump = 0, or ex_jump = 1 with ex_valid = 0 -> no redirect.
- Assert reset_n = 0 asynchronously mid-ISSUE (target 0x2040) -> outputs immediately show redirect_pc = 0x2000 and counters = 0. Also preset counters at 2^CNT_WIDTH − 1 and take a jump -> taken_count wraps to 0.
